truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 99 +++++++++
 tb/tb_truth_table_sweeper.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/capture engine: steps a WIDTH-bit code through every value,
// holds each for DWELL clocks, and records the sampled 1-bit response as a truth table.
module truth_table_sweeper #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DWELL = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    y_in,
  output logic [WIDTH-1:0]        x_out,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<WIDTH)-1:0]   truth_table,
  output logic [WIDTH:0]          ones_count
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL - 1);
  localparam logic [WIDTH-1:0] X_LAST   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DONE
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [WIDTH-1:0]        r_x;
  logic                    r_busy;
  logic                    r_done;
  logic [(1<<WIDTH)-1:0]   r_tt;
  logic [WIDTH:0]          r_ones;

  logic                    w_sample;

  // Sample only on the final dwell cycle so the function has DWELL-1 cycles to settle.
  assign w_sample = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tt    <= '0;
      r_ones  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_DRIVE;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_x     <= '0;
            r_tt    <= '0;
            r_ones  <= '0;
          end
        end
        ST_DRIVE: begin
          if (w_sample) begin
            r_tt[r_x] <= y_in;
            r_ones    <= r_ones + (WIDTH+1)'(y_in);
            r_cnt     <= '0;
            if (r_x == X_LAST) begin
              r_state <= ST_DONE;
              r_x     <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out       = r_x;
  assign busy        = r_busy;
  assign done        = r_done;
  assign truth_table = r_tt;
  assign ones_count  = r_ones;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a DWELL=20 instance for the main sweeps
// and a DWELL=4 instance for the settle-filter case.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start1, start2;
  logic        y1, y2;
  logic [4:0]  x1, x2;
  logic        busy1, busy2, done1, done2;
  logic [31:0] tt1, tt2;
  logic [5:0]  ones1, ones2;

  int          n_checks;
  int          n_errors;
  int          mode;
  int          phase2;

  truth_table_sweeper #(.WIDTH(5), .DWELL(20)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1), .x_out(x1),
    .busy(busy1), .done(done1), .truth_table(tt1), .ones_count(ones1)
  );

  truth_table_sweeper #(.WIDTH(5), .DWELL(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .y_in(y2), .x_out(x2),
    .busy(busy2), .done(done2), .truth_table(tt2), .ones_count(ones2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under test for the DWELL=20 instance, selected by mode.
  always_comb begin
    case (mode)
      0:       y1 = ^x1;
      1:       y1 = 1'b1;
      2:       y1 = 1'b0;
      default: y1 = (x1 == 5'b10101);
    endcase
  end

  // One-cycle glitch at the first cycle of every code on the DWELL=4 instance.
  always @(posedge clk) begin
    if (!busy2) phase2 <= 0;
    else        phase2 <= (phase2 + 1) % 4;
  end
  assign y2 = busy2 && (phase2 == 0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start on dut1; lat is the cycle number (relative to the accept edge) where done is seen.
  task automatic sweep1(output int lat);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done1 && lat < 2000);
    if (!done1) check("sweep1_timeout", 64'(lat), 64'd641);
  endtask

  task automatic sweep2(output int lat);
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done2 && lat < 2000);
    if (!done2) check("sweep2_timeout", 64'(lat), 64'd129);
  endtask

  initial begin
    int lat;
    int c;
    int last_done;
    int n_done;
    int done_at [0:3];
    bit ok;

    n_checks = 0;
    n_errors = 0;
    mode     = 0;
    start1   = 1'b0;
    start2   = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_x",    64'(x1),    64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_tt",   64'(tt1),   64'd0);
    check("rst_ones", 64'(ones1), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Parity
    mode = 0;
    sweep1(lat);
    check("parity_latency", 64'(lat),   64'd641);
    check("parity_tt",      64'(tt1),   64'h96696996);
    check("parity_ones",    64'(ones1), 64'd16);
    check("parity_x_done",  64'(x1),    64'd0);
    check("parity_busy_done", 64'(busy1), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done1), 64'd0);
    check("idle_hold_tt",   64'(tt1),   64'h96696996);

    // Constant one, then constant zero
    mode = 1;
    sweep1(lat);
    check("one_tt",   64'(tt1),   64'hFFFFFFFF);
    check("one_ones", 64'(ones1), 64'd32);
    mode = 2;
    sweep1(lat);
    check("zero_tt",   64'(tt1),   64'h0);
    check("zero_ones", 64'(ones1), 64'd0);

    // Single minterm, with x_out stepping checked every cycle
    mode = 3;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      if (x1 !== 5'(i / 20) || busy1 !== 1'b1) ok = 1'b0;
      if (i % 20 == 0 || i % 20 == 19) check("minterm_x_step", 64'(x1), 64'(i / 20));
    end
    check("minterm_busy_all", 64'(ok), 64'd1);
    @(negedge clk);
    check("minterm_done", 64'(done1), 64'd1);
    check("minterm_tt",   64'(tt1),   64'h00200000);
    check("minterm_ones", 64'(ones1), 64'd1);

    // Settle filter on the DWELL=4 instance
    sweep2(lat);
    check("settle_latency", 64'(lat),   64'd129);
    check("settle_tt",      64'(tt2),   64'h0);
    check("settle_ones",    64'(ones2), 64'd0);

    // Reset mid-sweep
    mode = 0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    c = 0;
    while (!(x1 == 5'd13 && busy1) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("reach_x13", 64'(x1), 64'd13);
    check("partial_tt_nonzero", 64'(tt1 != 0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_x",    64'(x1),    64'd0);
    check("async_rst_busy", 64'(busy1), 64'd0);
    check("async_rst_tt",   64'(tt1),   64'd0);
    check("async_rst_ones", 64'(ones1), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", 64'(busy1), 64'd0);
    check("post_rst_done", 64'(done1), 64'd0);
    check("post_rst_tt",   64'(tt1),   64'd0);
    check("post_rst_x",    64'(x1),    64'd0);
    sweep1(lat);
    check("post_rst_latency", 64'(lat), 64'd641);
    check("post_rst_tt2",     64'(tt1), 64'h96696996);
    @(negedge clk);

    // Start pulsed repeatedly while busy: no restart, one done
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    n_done = 0;
    lat = 0;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      start1 = (i % 37 == 0) && (i < 640);
      if (done1) begin
        n_done++;
        lat = i;
      end
    end
    start1 = 1'b0;
    check("busy_pulse_done_count", 64'(n_done), 64'd1);
    check("busy_pulse_latency",    64'(lat),    64'd641);
    check("busy_pulse_tt",         64'(tt1),    64'h96696996);

    // Start held for 2000 cycles: back-to-back sweeps
    @(negedge clk) start1 = 1'b1;
    n_done = 0;
    last_done = -10;
    for (c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c == last_done + 1) begin
        check("held_idle_busy", 64'(busy1), 64'd0);
        check("held_idle_done", 64'(done1), 64'd0);
      end
      if (c == last_done + 2) check("held_restart_busy", 64'(busy1), 64'd1);
      if (done1) begin
        if (n_done < 4) done_at[n_done] = c;
        n_done++;
        last_done = c;
      end
    end
    start1 = 1'b0;
    check("held_done_count", 64'(n_done), 64'd3);
    check("held_first_done", 64'(done_at[0]), 64'd640);
    check("held_gap1", 64'(done_at[1] - done_at[0]), 64'd642);
    check("held_gap2", 64'(done_at[2] - done_at[1]), 64'd642);
    c = 0;
    while (!done1 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("held_final_done", 64'(done1), 64'd1);
    check("held_final_tt",   64'(tt1),   64'h96696996);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
